// File: rtl/pipe_skid_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter with registered skid output.
// Imported by the interface, the picker and the top level.
package pipe_arb_pkg;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
    } data_t;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

    // Index width that stays legal for a single requester as well.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pipe_skid_rr_arbiter_if.sv
// Request fan-in and downstream stage bundle of the arbiter.
// slave is the arbiter's view, master the view of the surrounding logic.
interface pipe_skid_rr_arbiter_if #(
    parameter type DataT   = pipe_arb_pkg::data_t,
    parameter int  NUM_REQ = 4
);
    import pipe_arb_pkg::*;

    localparam int IDX_W = idx_w(NUM_REQ);

    logic [NUM_REQ-1:0] req_valid;
    DataT [NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0] req_last;
    logic [NUM_REQ-1:0] req_ready;
    logic               next_valid;
    DataT               next_data;
    logic [IDX_W-1:0]   next_src;
    logic               next_ready;

    modport slave (
        input  req_valid, req_data, req_last, next_ready,
        output req_ready, next_valid, next_data, next_src
    );

    modport master (
        output req_valid, req_data, req_last, next_ready,
        input  req_ready, next_valid, next_data, next_src
    );

endinterface

// File: rtl/pipe_skid_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping back to the lowest set request.
module rr_pick
    import pipe_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic [NUM_REQ-1:0] onehot_o
);

    // NOTE: every output gets a default before the loops, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        found_o  = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        // Descending scans leave the lowest match; the second scan overrides the wrap fallback.
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_i[j]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(j);
            end
        end
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_i[j] && (IDX_W'(j) >= ptr_i)) begin
                idx_o = IDX_W'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            onehot_o[j] = found_o && (idx_o == IDX_W'(j));
        end
    end

endmodule

// File: rtl/pipe_skid_rr_arbiter.sv
// Round-robin arbiter sharing one downstream stage between NUM_REQ requesters,
// with optional packet locking and a registered two-entry (output + skid) stage.
module pipe_skid_rr_arbiter
    import pipe_arb_pkg::*;
#(
    parameter type DataT        = pipe_arb_pkg::data_t,
    parameter int  NUM_REQ      = 4,
    parameter bit  OPT_PKT_LOCK = 1'b0
) (
    input logic                   clk,
    input logic                   rst,
    input logic                   clear,
    pipe_skid_rr_arbiter_if.slave bus
);

    localparam int IDX_W = idx_w(NUM_REQ);

    typedef struct packed {
        DataT             data;
        logic [IDX_W-1:0] src;
    } beat_t;

    arb_state_t         state_q;
    logic [NUM_REQ-1:0] grant_oh_q;
    logic [IDX_W-1:0]   grant_idx_q;
    logic [IDX_W-1:0]   rr_ptr_q;

    logic  out_valid_q, out_valid_d;
    logic  skid_valid_q, skid_valid_d;
    beat_t out_q, out_d;
    beat_t skid_q, skid_d;

    logic               granted, accept, release_grant, out_take;
    logic [IDX_W-1:0]   ptr_after_g, pick_ptr, pick_idx;
    logic               pick_found;
    logic [NUM_REQ-1:0] pick_oh;
    beat_t              in_beat;

    // Readiness depends only on registers, so next_ready never reaches req_ready.
    assign granted       = (state_q == GRANT);
    assign bus.req_ready = (granted && !skid_valid_q) ? grant_oh_q : '0;
    assign accept        = |(bus.req_valid & bus.req_ready);
    assign release_grant = accept && (!OPT_PKT_LOCK || |(bus.req_last & grant_oh_q));
    assign out_take      = out_valid_q && bus.next_ready;

    // Explicit wrap so non-power-of-two NUM_REQ never lands on an unused index.
    assign ptr_after_g = (grant_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_q + IDX_W'(1);
    assign pick_ptr    = granted ? ptr_after_g : rr_ptr_q;

    assign in_beat = '{data: bus.req_data[grant_idx_q], src: grant_idx_q};

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i    (bus.req_valid),
        .ptr_i    (pick_ptr),
        .found_o  (pick_found),
        .idx_o    (pick_idx),
        .onehot_o (pick_oh)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            state_q     <= IDLE;
            grant_oh_q  <= '0;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        state_q     <= GRANT;
                        grant_oh_q  <= pick_oh;
                        grant_idx_q <= pick_idx;
                    end
                end
                GRANT: begin
                    // Without a releasing handshake the grant is held, even if valid drops.
                    if (release_grant) begin
                        rr_ptr_q <= ptr_after_g;
                        if (pick_found) begin
                            grant_oh_q  <= pick_oh;
                            grant_idx_q <= pick_idx;
                        end else begin
                            state_q    <= IDLE;
                            grant_oh_q <= '0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (skid_valid_q) begin
            if (out_take) begin
                out_d        = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q || out_take) begin
                out_d       = in_beat;
                out_valid_d = 1'b1;
            end else begin
                skid_d       = in_beat;
                skid_valid_d = 1'b1;
            end
        end else if (out_take) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: payload registers are reset as well because next_data and next_src must read zero after reset.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_q        <= out_d;
            skid_q       <= skid_d;
        end
    end

    assign bus.next_valid = out_valid_q;
    assign bus.next_data  = out_q.data;
    assign bus.next_src   = out_q.src;

endmodule

// File: tb/tb_pipe_skid_rr_arbiter.sv
// Scoreboard bench: directed streams per requester, expected beats queued up
// front, per-instance monitors pop and compare on every downstream handshake.
module tb_pipe_skid_rr_arbiter;
    import pipe_arb_pkg::*;

    typedef struct packed {
        logic [1:0] src;
        data_t      data;
    } exp_t;

    logic clk, rst, clr4, clrl, clr3;
    int   n_checks, n_errors;

    // Per instance (0: 4 req, 1: 4 req locked, 2: 3 req) stream state per requester.
    int rem [3][4];
    int cnt [3][4];
    bit last_all [3][4];

    exp_t q4[$];
    exp_t ql[$];
    exp_t q3[$];
    exp_t e4, el, e3;

    pipe_skid_rr_arbiter_if #(.NUM_REQ(4)) if4 ();
    pipe_skid_rr_arbiter_if #(.NUM_REQ(4)) ifl ();
    pipe_skid_rr_arbiter_if #(.NUM_REQ(3)) if3 ();

    pipe_skid_rr_arbiter #(.NUM_REQ(4), .OPT_PKT_LOCK(1'b0)) u_dut4 (
        .clk(clk), .rst(rst), .clear(clr4), .bus(if4));
    pipe_skid_rr_arbiter #(.NUM_REQ(4), .OPT_PKT_LOCK(1'b1)) u_dutl (
        .clk(clk), .rst(rst), .clear(clrl), .bus(ifl));
    pipe_skid_rr_arbiter #(.NUM_REQ(3), .OPT_PKT_LOCK(1'b0)) u_dut3 (
        .clk(clk), .rst(rst), .clear(clr3), .bus(if3));

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1);
    end

    function automatic data_t mk(input int i, input int k);
        return '{x: 16'(i), y: 16'(k)};
    endfunction

    function automatic exp_t ex(input int i, input int k);
        return '{src: 2'(i), data: mk(i, k)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (if4.next_valid && if4.next_ready) begin
            if (q4.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL d4_extra_beat actual=src%0d/%h required=none", if4.next_src, if4.next_data);
            end else begin
                e4 = q4.pop_front();
                check("d4_beat", {if4.next_src, if4.next_data}, e4);
            end
        end
    end

    always @(negedge clk) begin
        if (ifl.next_valid && ifl.next_ready) begin
            if (ql.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL dl_extra_beat actual=src%0d/%h required=none", ifl.next_src, ifl.next_data);
            end else begin
                el = ql.pop_front();
                check("dl_beat", {ifl.next_src, ifl.next_data}, el);
            end
        end
    end

    always @(negedge clk) begin
        if (if3.next_valid && if3.next_ready) begin
            if (q3.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL d3_extra_beat actual=src%0d/%h required=none", if3.next_src, if3.next_data);
            end else begin
                e3 = q3.pop_front();
                check("d3_beat", {if3.next_src, if3.next_data}, e3);
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if4.req_valid[i] = rem[0][i] > 0;
            if4.req_data[i]  = mk(i, cnt[0][i]);
            if4.req_last[i]  = last_all[0][i] || (rem[0][i] == 1);
            ifl.req_valid[i] = rem[1][i] > 0;
            ifl.req_data[i]  = mk(i, cnt[1][i]);
            ifl.req_last[i]  = last_all[1][i] || (rem[1][i] == 1);
        end
        for (int i = 0; i < 3; i++) begin
            if3.req_valid[i] = rem[2][i] > 0;
            if3.req_data[i]  = mk(i, cnt[2][i]);
            if3.req_last[i]  = last_all[2][i] || (rem[2][i] == 1);
        end
    endtask

    // One clock: sample handshakes at negedge, advance the streams just after posedge.
    task automatic tick();
        logic [3:0] h0, h1;
        logic [2:0] h2;
        @(negedge clk);
        h0 = if4.req_valid & if4.req_ready;
        h1 = ifl.req_valid & ifl.req_ready;
        h2 = if3.req_valid & if3.req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (h0[i]) begin cnt[0][i]++; rem[0][i]--; end
            if (h1[i]) begin cnt[1][i]++; rem[1][i]--; end
            if (i < 3 && h2[i]) begin cnt[2][i]++; rem[2][i]--; end
        end
        drive();
    endtask

    task automatic start_test();
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 4; i++) begin
                rem[d][i]      = 0;
                cnt[d][i]      = 0;
                last_all[d][i] = 1'b0;
            end
        end
        drive();
        tick();
        tick();
    endtask

    task automatic drain(input int budget);
        for (int t = 0; t < budget && (q4.size() + ql.size() + q3.size()) != 0; t++) begin
            tick();
        end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b0;
        clr4 = 1'b0;
        clrl = 1'b0;
        clr3 = 1'b0;
        n_checks = 0;
        n_errors = 0;
        if4.next_ready = 1'b1;
        ifl.next_ready = 1'b1;
        if3.next_ready = 1'b1;
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 4; i++) begin
                rem[d][i] = 0; cnt[d][i] = 0; last_all[d][i] = 1'b0;
            end
        end

        // Reset with every requester valid, then fair rotation at full rate.
        for (int i = 0; i < 4; i++) rem[0][i] = 3;
        drive();
        repeat (3) begin
            tick();
            check("rst_req_ready", if4.req_ready, 4'b0000);
            check("rst_next_valid", if4.next_valid, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) q4.push_back(ex(i, k));
        end
        rst = 1'b1;
        tick();
        check("first_grant", if4.req_ready, 4'b0001);
        check("first_grant_nv", if4.next_valid, 1'b0);
        tick();
        check("second_grant", if4.req_ready, 4'b0010);
        for (int b = 0; b < 12; b++) begin
            check("gapless", if4.next_valid, 1'b1);
            tick();
        end
        check("fair_idle", if4.next_valid, 1'b0);
        check("fair_drained", q4.size(), 0);

        // Backpressure on a single requester.
        start_test();
        if4.next_ready = 1'b0;
        rem[0][1] = 5;
        drive();
        for (int k = 0; k < 5; k++) q4.push_back(ex(1, k));
        rst = 1'b1;
        tick();
        check("bp_grant", if4.req_ready, 4'b0010);
        tick();
        check("bp_out0", {if4.next_valid, if4.next_src, if4.next_data}, {1'b1, 2'd1, mk(1, 0)});
        check("bp_ready_1st", if4.req_ready, 4'b0010);
        tick();
        for (int c = 0; c < 3; c++) begin
            check("bp_ready_low", if4.req_ready, 4'b0000);
            check("bp_stable", {if4.next_valid, if4.next_src, if4.next_data}, {1'b1, 2'd1, mk(1, 0)});
            tick();
        end
        check("bp_accepted", cnt[0][1], 2);
        if4.next_ready = 1'b1;
        drain(20);
        check("bp_drained", q4.size(), 0);
        check("bp_all_sent", cnt[0][1], 5);

        // Packet lock: req2 packet of 4 beats is not interleaved with req0.
        start_test();
        rem[1][0] = 3;
        last_all[1][0] = 1'b1;
        rem[1][2] = 4;
        drive();
        ql.push_back(ex(0, 0));
        for (int k = 0; k < 4; k++) ql.push_back(ex(2, k));
        ql.push_back(ex(0, 1));
        ql.push_back(ex(0, 2));
        rst = 1'b1;
        drain(30);
        check("lock_drained", ql.size(), 0);
        check("lock_req0_sent", cnt[1][0], 3);

        // Three requesters, pointer at 2, wrap back to 0.
        start_test();
        rem[2][1] = 1;
        drive();
        q3.push_back(ex(1, 0));
        q3.push_back(ex(2, 0));
        q3.push_back(ex(0, 0));
        q3.push_back(ex(2, 1));
        q3.push_back(ex(0, 1));
        rst = 1'b1;
        tick();
        check("nr3_grant1", if3.req_ready, 3'b010);
        rem[2][0] = 2;
        rem[2][2] = 2;
        drive();
        drain(30);
        check("nr3_drained", q3.size(), 0);

        // Clear with the skid entry full: in-flight beats vanish, pointer restarts at 0.
        start_test();
        if4.next_ready = 1'b0;
        rem[0][1] = 4;
        drive();
        rst = 1'b1;
        tick();
        tick();
        tick();
        check("clr_skid_full", if4.req_ready, 4'b0000);
        clr4 = 1'b1;
        tick();
        check("clr_next_valid", if4.next_valid, 1'b0);
        check("clr_req_ready", if4.req_ready, 4'b0000);
        check("clr_next_bus", {if4.next_src, if4.next_data}, 34'd0);
        clr4 = 1'b0;
        q4.push_back(ex(1, 2));
        q4.push_back(ex(3, 0));
        q4.push_back(ex(1, 3));
        rem[0][3] = 1;
        drive();
        if4.next_ready = 1'b1;
        drain(30);
        check("clr_drained", q4.size(), 0);
        repeat (3) begin
            tick();
            check("clr_no_stale", if4.next_valid, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
